// File: rtl/lvds_tx_data_mux_pkg.sv
// Shared definitions for the LVDS TX word source: FSM states, mode codes and default words.
package lvds_tx_data_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_USER  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_AUTO        = 2'b00,
    MODE_FORCE_ALIGN = 2'b01,
    MODE_FORCE_USER  = 2'b10,
    MODE_AUTO_ALT    = 2'b11
  } mode_t;

  localparam logic [7:0] DEF_ALIGN_WORD = 8'hE4;
  localparam logic [7:0] DEF_IDLE_WORD  = 8'h00;

endpackage

// File: rtl/lvds_tx_data_mux_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// The head register adds one cycle of latency between a write and the word being poppable.
module lvds_tx_data_mux_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign rd_nxt  = rd_ptr + PW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // full reads 1 while in reset so nothing is accepted until the first active cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_ptr == rd_nxt);
      dout   <= mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/lvds_tx_data_mux.sv
// Per-link TX word source: training word after reset/realign, then user FIFO data padded with idle words.
module lvds_tx_data_mux
  import lvds_tx_data_mux_pkg::*;
#(
  parameter int unsigned   CH_NUM       = 2,
  parameter int unsigned   DW           = 8,
  parameter logic [DW-1:0] ALIGN_WORD   = DW'(DEF_ALIGN_WORD),
  parameter logic [DW-1:0] IDLE_WORD    = DW'(DEF_IDLE_WORD),
  parameter int unsigned   ALIGN_CYCLES = 1024,
  parameter int unsigned   FIFO_DEPTH   = 16
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic [1:0]           I_mode,
  input  logic                 I_realign,
  input  logic                 I_user_valid,
  input  logic [CH_NUM*DW-1:0] I_user_data,
  output logic                 O_user_ready,
  output logic                 O_valid,
  output logic [CH_NUM*DW-1:0] O_data,
  output logic                 O_aligned,
  output logic                 O_underrun
);

  localparam int unsigned   WW        = CH_NUM * DW;
  localparam int unsigned   CW        = $clog2(ALIGN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(ALIGN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(ALIGN_CYCLES);
  localparam logic [WW-1:0] ALIGN_BUS = {CH_NUM{ALIGN_WORD}};
  localparam logic [WW-1:0] IDLE_BUS  = {CH_NUM{IDLE_WORD}};

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WW-1:0] fifo_dout;
  logic          seen_word;
  logic          force_user, force_align, align_done;

  assign force_user   = (I_mode == MODE_FORCE_USER);
  assign force_align  = (I_mode == MODE_FORCE_ALIGN);
  assign align_done   = (cnt >= CNT_LAST);
  assign fifo_push    = I_user_valid && O_user_ready;
  assign fifo_pop     = (state_nxt == ST_USER) && !fifo_empty;
  assign O_user_ready = !fifo_full;

  lvds_tx_data_mux_sync_fifo #(
    .WIDTH(WW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (I_clk),
    .rst_n(I_rst),
    .push (fifo_push),
    .din  (I_user_data),
    .full (fifo_full),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .empty(fifo_empty)
  );

  // Next state: forced USER beats realign, realign beats counter completion
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (force_user) begin
      state_nxt = ST_USER;
    end else if (I_realign && (state != ST_IDLE)) begin
      state_nxt = ST_ALIGN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_ALIGN;
          cnt_nxt   = '0;
        end
        ST_ALIGN: begin
          if (align_done && !force_align) state_nxt = ST_USER;
          else if (cnt != CNT_MAX)        cnt_nxt   = cnt + CW'(1);
        end
        ST_USER: begin
          if (force_align) begin
            state_nxt = ST_ALIGN;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      seen_word  <= 1'b0;
      O_valid    <= 1'b0;
      O_data     <= '0;
      O_aligned  <= 1'b0;
      O_underrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      O_aligned <= (state_nxt == ST_USER);
      case (state_nxt)
        ST_ALIGN: begin
          O_valid <= 1'b1;
          O_data  <= ALIGN_BUS;
        end
        ST_USER: begin
          if (!fifo_empty) begin
            O_valid   <= 1'b1;
            O_data    <= fifo_dout;
            seen_word <= 1'b1;
          end else begin
            O_valid <= 1'b0;
            O_data  <= IDLE_BUS;
            if (seen_word) O_underrun <= 1'b1;
          end
        end
        default: begin
          O_valid <= 1'b0;
          O_data  <= '0;
        end
      endcase
    end
  end

endmodule
